// File: rtl/tall_skinny_result_collector_if.sv
// Purpose: element-in / row-out stream bundle for the tall-skinny result collector.
// Latency: none (wires only).
// Backpressure: slave drives in_ready upstream; master drives row_ready downstream.
// Ports: valid_in/data_in/in_ready (element stream), row_valid/row_data/row_last/row_ready (row stream).
interface tall_skinny_result_collector_if #(
  parameter int DATA_W = 32,
  parameter int N_COLS = 4
);
  logic                     valid_in;
  logic [DATA_W-1:0]        data_in;
  logic                     in_ready;
  logic                     row_valid;
  logic [N_COLS*DATA_W-1:0] row_data;
  logic                     row_last;
  logic                     row_ready;

  // Producer of elements and consumer of rows.
  modport master (
    output valid_in, data_in, row_ready,
    input  in_ready, row_valid, row_data, row_last
  );

  // The collector itself.
  modport slave (
    input  valid_in, data_in, row_ready,
    output in_ready, row_valid, row_data, row_last
  );
endinterface

// File: rtl/tall_skinny_result_collector.sv
// Purpose: packs a row-major element stream into N_COLS-wide rows, buffered in a row FIFO.
// Latency: 1 cycle from the row-completing element to row_valid when the FIFO is empty.
// Backpressure: in_ready drops when the FIFO is full or outside COLLECT; rows hold until row_ready.
// Ports: clk, rst_n (sync active-low), start/num_rows (job launch), bus (element in / row out),
//        busy, done (pulse), overflow_err (sticky, element offered while in_ready low).
module tall_skinny_result_collector #(
  parameter int DATA_W     = 32,
  parameter int N_COLS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [15:0]                   num_rows,
  tall_skinny_result_collector_if.slave bus,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow_err
);

  localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ROW_W = N_COLS * DATA_W;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [15:0]      row_cnt_q, row_cnt_d;
  logic [15:0]      target_q, target_d;
  logic [ROW_W-1:0] asm_q, asm_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  // Each entry carries the row's last flag above the packed row.
  logic [ROW_W:0]   mem_q [FIFO_DEPTH];

  logic             accept;
  logic             push;
  logic             pop;
  logic             row_is_last;
  logic             head_last;
  logic [ROW_W-1:0] row_full;

  // No pop bypass: a full FIFO refuses elements even if a row leaves this cycle.
  assign bus.in_ready  = (state_q == COLLECT) && (cnt_q < (AW+1)'(FIFO_DEPTH));
  assign accept        = bus.valid_in && bus.in_ready;
  assign push          = accept && (col_q == CW'(N_COLS - 1));
  assign bus.row_valid = (cnt_q != '0);
  assign pop           = bus.row_valid && bus.row_ready;
  assign head_last     = mem_q[rd_ptr_q][ROW_W];
  // Gate the head so idle/reset outputs read as zero regardless of stale storage.
  assign bus.row_data  = bus.row_valid ? mem_q[rd_ptr_q][ROW_W-1:0] : '0;
  assign bus.row_last  = bus.row_valid && head_last;
  assign row_is_last   = (row_cnt_q == target_q - 16'd1);

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign overflow_err  = ovf_q;

  // Completed row includes the element arriving this cycle.
  always_comb begin
    row_full = asm_q;
    row_full[col_q*DATA_W +: DATA_W] = bus.data_in;
    asm_d = accept ? row_full : asm_q;
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_cnt_d = row_cnt_q;
    target_d  = target_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    if (bus.valid_in && !bus.in_ready) ovf_d = 1'b1;
    if (accept) col_d = push ? '0 : col_q + CW'(1);
    if (push)   row_cnt_d = row_cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_rows != 16'd0) begin
            state_d   = COLLECT;
            target_d  = num_rows;
            col_d     = '0;
            row_cnt_d = '0;
            ovf_d     = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (push && row_is_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_cnt_q <= '0;
      target_q  <= '0;
      asm_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_cnt_q <= row_cnt_d;
      target_q  <= target_d;
      asm_q     <= asm_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {row_is_last, row_full};
  end

endmodule

// File: tb/tb_tall_skinny_result_collector.sv
module tb_tall_skinny_result_collector;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int FD = 8;
  localparam int RW = NC * DW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_rows;
  logic        busy, done, ovf;

  always #5 clk = ~clk;

  tall_skinny_result_collector_if #(.DATA_W(DW), .N_COLS(NC)) bus ();

  tall_skinny_result_collector #(.DATA_W(DW), .N_COLS(NC), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_rows     (num_rows),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .overflow_err (ovf)
  );

  // row_ready is either driven directly or toggled every cycle.
  logic rr_man;
  logic tgl_en;
  logic tgl_q = 1'b0;
  always @(posedge clk) tgl_q <= ~tgl_q;
  assign bus.row_ready = tgl_en ? tgl_q : rr_man;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int done_cnt = 0;

  logic [RW:0] sb [$];

  task automatic chk(input string tag, input logic [RW:0] obs, input logic [RW:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, done timing.
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data  = '0;
  logic          pend_done  = 1'b0;
  logic [RW:0]   exp_row;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (pend_done) chk("done_after_last_pop", done, 1'b1);
    pend_done = 1'b0;
    if (prev_stall && rst_n) begin
      chk("stall_valid", bus.row_valid, 1'b1);
      chk("stall_data", bus.row_data, prev_data);
    end
    if (rst_n && bus.row_valid && bus.row_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_row", bus.row_valid, 1'b0);
      end else begin
        exp_row = sb.pop_front();
        chk("row", {bus.row_last, bus.row_data}, exp_row);
        if (exp_row[RW]) pend_done = 1'b1;
      end
    end
    prev_stall = rst_n && bus.row_valid && !bus.row_ready;
    prev_data  = bus.row_data;
  end

  // Reference row model.
  int          m_col, m_row, m_rows;
  logic [RW-1:0] m_cur;

  task automatic start_job(input int m);
    m_rows = m; m_col = 0; m_row = 0; m_cur = '0;
    start = 1'b1; num_rows = 16'(m);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    while (!bus.in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("send_timeout", bus.in_ready, 1'b1);
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    m_cur[m_col*DW +: DW] = d;
    if (m_col == NC - 1) begin
      sb.push_back({(m_row == m_rows - 1), m_cur});
      m_col = 0;
      m_row++;
    end else begin
      m_col++;
    end
  endtask

  task automatic wait_done(input int exp_cnt);
    int n = 0;
    while (done_cnt < exp_cnt && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("done_count", done_cnt, exp_cnt);
    chk("busy_after_job", busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_row_valid"}, bus.row_valid, 1'b0);
    chk({tag, "_row_last"}, bus.row_last, 1'b0);
    chk({tag, "_row_data"}, bus.row_data, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_rows = '0;
    bus.valid_in = 1'b0; bus.data_in = '0;
    rr_man = 1'b1; tgl_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-row job, elements 1..8, always ready.
    start_job(2);
    chk("busy_in_job", busy, 1'b1);
    for (int i = 1; i <= 4; i++) send(DW'(i));
    chk("first_row_latency", bus.row_valid, 1'b1);
    for (int i = 5; i <= 8; i++) send(DW'(i));
    wait_done(1);

    // Ten rows with downstream stalled: FIFO fills after 8 rows.
    rr_man = 1'b0;
    start_job(10);
    for (int i = 0; i < 32; i++) send(DW'(100 + i));
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_row_valid", bus.row_valid, 1'b1);
    chk("full_no_ovf", ovf, 1'b0);
    rr_man = 1'b1;
    for (int i = 32; i < 40; i++) send(DW'(100 + i));
    wait_done(2);

    // row_ready toggling each cycle.
    tgl_en = 1'b1;
    start_job(3);
    for (int i = 0; i < 12; i++) send(DW'(200 + i));
    wait_done(3);
    tgl_en = 1'b0;

    // Element offered in IDLE sets sticky overflow; next start clears it.
    bus.valid_in = 1'b1; bus.data_in = 32'hdead_beef;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    chk("ovf_set", ovf, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", ovf, 1'b1);
    chk("ovf_no_row", bus.row_valid, 1'b0);
    start_job(1);
    chk("ovf_cleared", ovf, 1'b0);
    for (int i = 0; i < 4; i++) send(DW'(400 + i));
    wait_done(4);

    // Zero-row job.
    start = 1'b1; num_rows = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("zero_done_pulse", done, 1'b0);
    chk("zero_busy_after", busy, 1'b0);
    chk("zero_done_count", done_cnt, 5);

    // Reset in the middle of a four-row job, then a clean job.
    start_job(4);
    for (int i = 0; i < 5; i++) send(DW'(300 + i));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_job(2);
    for (int i = 0; i < 8; i++) send(DW'(500 + i));
    wait_done(6);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
